lenet_layer_sched: RTL and testbench
====================================

LENET_LAYER_SCHED -- requirements
Module: lenet_layer_sched

Interface
REQ-001 Parameter NUM_LAYERS, default 6, number of sequenced layers (0=conv1, 1=pool1, 2=conv2, 3=pool2, 4=fc_1, 5=fc_2).
REQ-002 Parameter GAP_CYCLES, default 2, idle cycles inserted between layers.
REQ-003 Parameter TIMEOUT, default 2^24, maximum cycles one layer may run before error.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset rst, synchronous, active-high.
REQ-006 start  input  1  single-cycle pulse; starts one full inference pass.
REQ-007 abort  input  1  level; terminates the current pass.
REQ-008 layer_finish  input  NUM_LAYERS  per-layer one-cycle finish pulse.
REQ-009 layer_en  output  NUM_LAYERS  one-hot enable to the active layer.
REQ-010 cur_layer  output  3  index of the active layer; 7 when none is active.
REQ-011 busy  output  1  high from start acceptance until DONE/ERR/IDLE entry.
REQ-012 done  output  1  one-cycle pulse when the pass completes.
REQ-013 err  output  1  sticky timeout flag.
REQ-014 rb_ena_req, rb_wea_req  input  NUM_LAYERS each  per-layer result-BRAM enable/write requests.
REQ-015 rb_addra_req  input  15*NUM_LAYERS  per-layer result-BRAM address; layer i occupies bits [15i+14:15i].
REQ-016 rb_dina_req  input  8*NUM_LAYERS  per-layer result-BRAM write data.
REQ-017 bw_ena_req  input  NUM_LAYERS  per-layer bias/weights-BRAM enable.
REQ-018 bw_addra_req  input  19*NUM_LAYERS  per-layer bias/weights-BRAM address.
REQ-019 result_bram_ena, result_bram_wea  output  1 each  to the shared result BRAM.
REQ-020 result_bram_addra  output  15; result_bram_dina  output  8  to the shared result BRAM.
REQ-021 bias_weights_bram_ena  output  1; bias_weights_bram_addra  output  19  to the shared weight ROM.

Function
REQ-022 FSM states: IDLE, RUN, GAP, DONE, ERR.
REQ-023 IDLE: busy=0 and layer_en=0. A start pulse moves the FSM to RUN with layer index 0 and busy=1 on the next cycle.
REQ-024 RUN: layer_en has exactly bit cur_layer set, and the timeout counter increments every cycle.
REQ-025 RUN, layer_finish[cur_layer]=1: layer_en clears on the next cycle, and the FSM enters GAP with the gap counter set to 0.
- If cur_layer = NUM_LAYERS-1, it enters DONE instead.
REQ-026 GAP: layer_en=0 and cur_layer=7. After GAP_CYCLES cycles the FSM increments the layer index and returns to RUN.
REQ-027 DONE: done=1 for exactly one cycle, busy drops in the same cycle, then IDLE.
REQ-028 layer_finish bits other than the active layer, and any finish seen outside RUN, are ignored.
REQ-029 start while busy=1 is ignored. start and a final finish in the same cycle: the finish is honoured and the start is dropped.
REQ-030 Timeout counter reaches TIMEOUT-1 in RUN: the FSM enters ERR, err=1, layer_en=0, busy=0.
- ERR leaves only on rst.
- start in ERR is ignored.
REQ-031 abort=1 in RUN or GAP: IDLE on the next cycle, layer_en=0, busy=0, no done pulse. abort has priority over finish and timeout.
REQ-032 BRAM mux is combinational, selected by cur_layer.
- When cur_layer=7, all ena/wea outputs are 0, and addr/data outputs are 0.
REQ-033 Requests from non-selected layers never reach the BRAM outputs.
REQ-034 The timeout counter is 24 bits, cleared on every entry to RUN, and saturates (no wrap).

Reset
REQ-035 On rst: state=IDLE, layer index=0, cur_layer=7, layer_en=0, busy=0, done=0, err=0, and all counters=0.
REQ-036 rst asserted mid-pass forces the reset values on the next edge, overriding all other inputs.

Structure
REQ-037 Layer indices, NUM_LAYERS, bus widths (data 8, result addr 15, weight addr 19) and state encodings belong in the shared LeNet constants package.
REQ-038 One sub-module, lenet_bram_mux: a purely combinational port mux that takes the select plus the request buses; the FSM is kept in the top module.

Verification
REQ-039 start; each layer returns finish 10 cycles after its enable -> layer_en walks 0x01..0x20 with 2-cycle gaps, done pulses once, busy spans the pass.
REQ-040 Layer 4 active, rb_addra_req slice4=18400 with ena=1, other slices=0x7FFF -> result_bram_addra=18400, ena=1. In GAP -> ena=0, addra=0.
REQ-041 TIMEOUT=64, layer 2 never finishes -> err=1 at cycle 64 of layer 2, layer_en=0, and a subsequent start is ignored until rst.
REQ-042 abort during layer 3 in the same cycle as layer_finish[3] -> IDLE, no done, layer_en=0 next cycle.
REQ-043 rst asserted in the cycle after start -> all outputs at reset values. A stray layer_finish[1] in IDLE or RUN-layer0 has no effect.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared LeNet constants: layer indices, bus widths and scheduler state codes.
package lenet_pkg;

    localparam int LENET_NUM_LAYERS = 6;
    localparam int LENET_IDX_W      = 3;
    localparam int LENET_DATA_W     = 8;
    localparam int LENET_RADDR_W    = 15;
    localparam int LENET_WADDR_W    = 19;
    localparam int LENET_TMO_W      = 24;

    // Layer order through one inference pass; L_NONE marks "no layer active".
    localparam logic [LENET_IDX_W-1:0] L_CONV1 = 3'd0;
    localparam logic [LENET_IDX_W-1:0] L_POOL1 = 3'd1;
    localparam logic [LENET_IDX_W-1:0] L_CONV2 = 3'd2;
    localparam logic [LENET_IDX_W-1:0] L_POOL2 = 3'd3;
    localparam logic [LENET_IDX_W-1:0] L_FC1   = 3'd4;
    localparam logic [LENET_IDX_W-1:0] L_FC2   = 3'd5;
    localparam logic [LENET_IDX_W-1:0] L_NONE  = 3'd7;

    // Scheduler state encodings.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_GAP  = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [LENET_TMO_W-1:0] sat_inc_tmo(input logic [LENET_TMO_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lenet_bram_mux.sv
// Combinational port mux: forwards the selected layer's BRAM requests to the
// shared result BRAM and weight ROM. Any select outside the layer range
// (L_NONE in particular) drives every output to zero.
module lenet_bram_mux
    import lenet_pkg::*;
#(
    parameter int NUM_LAYERS = LENET_NUM_LAYERS
) (
    input  logic [LENET_IDX_W-1:0]              sel,
    input  logic [NUM_LAYERS-1:0]               rb_ena_req,
    input  logic [NUM_LAYERS-1:0]               rb_wea_req,
    input  logic [LENET_RADDR_W*NUM_LAYERS-1:0] rb_addra_req,
    input  logic [LENET_DATA_W*NUM_LAYERS-1:0]  rb_dina_req,
    input  logic [NUM_LAYERS-1:0]               bw_ena_req,
    input  logic [LENET_WADDR_W*NUM_LAYERS-1:0] bw_addra_req,
    output logic                                result_bram_ena,
    output logic                                result_bram_wea,
    output logic [LENET_RADDR_W-1:0]            result_bram_addra,
    output logic [LENET_DATA_W-1:0]             result_bram_dina,
    output logic                                bias_weights_bram_ena,
    output logic [LENET_WADDR_W-1:0]            bias_weights_bram_addra
);

    // Select one layer's slice; unselected layers can never leak through.
    always_comb begin
        result_bram_ena         = 1'b0;
        result_bram_wea         = 1'b0;
        result_bram_addra       = '0;
        result_bram_dina        = '0;
        bias_weights_bram_ena   = 1'b0;
        bias_weights_bram_addra = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (sel == LENET_IDX_W'(i)) begin
                result_bram_ena         = rb_ena_req[i];
                result_bram_wea         = rb_wea_req[i];
                result_bram_addra       = rb_addra_req[LENET_RADDR_W*i +: LENET_RADDR_W];
                result_bram_dina        = rb_dina_req[LENET_DATA_W*i +: LENET_DATA_W];
                bias_weights_bram_ena   = bw_ena_req[i];
                bias_weights_bram_addra = bw_addra_req[LENET_WADDR_W*i +: LENET_WADDR_W];
            end
        end
    end

endmodule

// File: rtl/lenet_layer_sched.sv
// LeNet layer scheduler: walks conv1..fc_2 one at a time, inserting idle gaps,
// with per-layer timeout, abort, and a BRAM port mux following the active layer.
// GAP_CYCLES must be at least 1.
module lenet_layer_sched
    import lenet_pkg::*;
#(
    parameter int          NUM_LAYERS = LENET_NUM_LAYERS,
    parameter int          GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 2**24
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                abort,
    input  logic [NUM_LAYERS-1:0]               layer_finish,
    output logic [NUM_LAYERS-1:0]               layer_en,
    output logic [LENET_IDX_W-1:0]              cur_layer,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    input  logic [NUM_LAYERS-1:0]               rb_ena_req,
    input  logic [NUM_LAYERS-1:0]               rb_wea_req,
    input  logic [LENET_RADDR_W*NUM_LAYERS-1:0] rb_addra_req,
    input  logic [LENET_DATA_W*NUM_LAYERS-1:0]  rb_dina_req,
    input  logic [NUM_LAYERS-1:0]               bw_ena_req,
    input  logic [LENET_WADDR_W*NUM_LAYERS-1:0] bw_addra_req,
    output logic                                result_bram_ena,
    output logic                                result_bram_wea,
    output logic [LENET_RADDR_W-1:0]            result_bram_addra,
    output logic [LENET_DATA_W-1:0]             result_bram_dina,
    output logic                                bias_weights_bram_ena,
    output logic [LENET_WADDR_W-1:0]            bias_weights_bram_addra
);

    localparam int GAP_W = 16;

    logic [2:0]             state_q, state_d;
    logic [LENET_IDX_W-1:0] idx_q, idx_d;
    logic [LENET_TMO_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0]       gap_q, gap_d;

    // Next-state logic; abort outranks finish, and finish outranks timeout.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    tmo_d   = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (layer_finish[idx_q]) begin
                    gap_d   = '0;
                    state_d = (idx_q == LENET_IDX_W'(NUM_LAYERS-1)) ? ST_DONE : ST_GAP;
                end else if (tmo_q == LENET_TMO_W'(TIMEOUT-1)) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_d = sat_inc_tmo(tmo_q);
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (gap_q == GAP_W'(GAP_CYCLES-1)) begin
                    state_d = ST_RUN;
                    idx_d   = idx_q + 1'b1;
                    tmo_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
        end
    end

    assign cur_layer = (state_q == ST_RUN) ? idx_q : L_NONE;
    assign layer_en  = (state_q == ST_RUN) ? (NUM_LAYERS'(1) << idx_q) : '0;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_GAP);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);

    lenet_bram_mux #(.NUM_LAYERS(NUM_LAYERS)) u_mux (
        .sel                     (cur_layer),
        .rb_ena_req              (rb_ena_req),
        .rb_wea_req              (rb_wea_req),
        .rb_addra_req            (rb_addra_req),
        .rb_dina_req             (rb_dina_req),
        .bw_ena_req              (bw_ena_req),
        .bw_addra_req            (bw_addra_req),
        .result_bram_ena         (result_bram_ena),
        .result_bram_wea         (result_bram_wea),
        .result_bram_addra       (result_bram_addra),
        .result_bram_dina        (result_bram_dina),
        .bias_weights_bram_ena   (bias_weights_bram_ena),
        .bias_weights_bram_addra (bias_weights_bram_addra)
    );

endmodule

// File: tb/tb_lenet_layer_sched.sv
// Bench for lenet_layer_sched: behavioural pass model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lenet_layer_sched;

    localparam int NL  = 6;
    localparam int GAP = 2;
    localparam int TMO = 64;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [NL-1:0]     layer_finish, layer_en;
    logic [2:0]        cur_layer;
    logic              busy, done, err;
    logic [NL-1:0]     rb_ena_req, rb_wea_req, bw_ena_req;
    logic [15*NL-1:0]  rb_addra_req;
    logic [8*NL-1:0]   rb_dina_req;
    logic [19*NL-1:0]  bw_addra_req;
    logic              result_bram_ena, result_bram_wea, bias_weights_bram_ena;
    logic [14:0]       result_bram_addra;
    logic [7:0]        result_bram_dina;
    logic [18:0]       bias_weights_bram_addra;

    lenet_layer_sched #(.NUM_LAYERS(NL), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .layer_finish(layer_finish), .layer_en(layer_en), .cur_layer(cur_layer),
        .busy(busy), .done(done), .err(err),
        .rb_ena_req(rb_ena_req), .rb_wea_req(rb_wea_req), .rb_addra_req(rb_addra_req),
        .rb_dina_req(rb_dina_req), .bw_ena_req(bw_ena_req), .bw_addra_req(bw_addra_req),
        .result_bram_ena(result_bram_ena), .result_bram_wea(result_bram_wea),
        .result_bram_addra(result_bram_addra), .result_bram_dina(result_bram_dina),
        .bias_weights_bram_ena(bias_weights_bram_ena),
        .bias_weights_bram_addra(bias_weights_bram_addra)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Pass model: which layer is enabled (-1 none), how long it has run,
    // remaining gap cycles, and the layer that follows the gap.
    int  m_layer = -1, m_age = 0, m_gap_left = 0, m_next = 0;
    bit  m_done = 0, m_err = 0;

    int      fin_lat [NL];   // finish after this many enabled cycles; 0 = never
    logic [NL-1:0] stray = '0;
    bit      rand_req = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return (m_layer >= 0) || (m_gap_left > 0);
    endfunction

    function automatic bit m_idle();
        return !m_busy() && !m_done && !m_err;
    endfunction

    function automatic logic [NL-1:0] auto_fin();
        if (m_layer >= 0 && fin_lat[m_layer] != 0 && m_age == fin_lat[m_layer] - 1)
            return NL'(1) << m_layer;
        return '0;
    endfunction

    task automatic check_all();
        int l;
        l = m_layer;
        chk("layer_en", layer_en, (l >= 0) ? (64'd1 << l) : 64'd0);
        chk("cur_layer", cur_layer, (l >= 0) ? l : 7);
        chk("busy", busy, m_busy());
        chk("done", done, m_done);
        chk("err", err, m_err);
        if (l >= 0) begin
            chk("rb_ena", result_bram_ena, rb_ena_req[l]);
            chk("rb_wea", result_bram_wea, rb_wea_req[l]);
            chk("rb_addra", result_bram_addra, rb_addra_req[15*l +: 15]);
            chk("rb_dina", result_bram_dina, rb_dina_req[8*l +: 8]);
            chk("bw_ena", bias_weights_bram_ena, bw_ena_req[l]);
            chk("bw_addra", bias_weights_bram_addra, bw_addra_req[19*l +: 19]);
        end else begin
            chk("rb_idle", {result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina}, 0);
            chk("bw_idle", {bias_weights_bram_ena, bias_weights_bram_addra}, 0);
        end
    endtask

    // Advance the pass model by one clock using the inputs seen at that edge.
    task automatic model_step();
        if (rst) begin
            m_layer = -1; m_age = 0; m_gap_left = 0; m_next = 0; m_done = 0; m_err = 0;
        end else if (m_err) begin
            // only reset leaves the error condition
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy()) begin
            if (abort) begin
                m_layer = -1; m_gap_left = 0;
            end else if (m_layer >= 0) begin
                if (layer_finish[m_layer]) begin
                    if (m_layer == NL - 1) m_done = 1;
                    else begin m_next = m_layer + 1; m_gap_left = GAP; end
                    m_layer = -1;
                end else if (m_age == TMO - 1) begin
                    m_err = 1; m_layer = -1;
                end else m_age++;
            end else begin
                m_gap_left--;
                if (m_gap_left == 0) begin m_layer = m_next; m_age = 0; end
            end
        end else if (start) begin
            m_layer = 0; m_age = 0;
        end
    endtask

    // One clock: drive finish/request inputs, compare, step model, clear pulses.
    task automatic tick();
        layer_finish = stray | auto_fin();
        if (rand_req) begin
            for (int i = 0; i < NL; i++) begin
                rb_addra_req[15*i +: 15] = 15'($urandom);
                rb_dina_req[8*i +: 8]    = 8'($urandom);
                bw_addra_req[19*i +: 19] = 19'($urandom);
            end
            rb_ena_req = NL'($urandom);
            rb_wea_req = NL'($urandom);
            bw_ena_req = NL'($urandom);
        end
        #1 check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
        start = 1'b0;
        stray = '0;
    endtask

    task automatic run_to_idle(input int bound);
        int n;
        n = 0;
        while (!m_idle() && n < bound) begin tick(); n++; end
        chk("wait_idle", m_idle(), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, busy_n, done_n, done_at, nseq, ok;
        logic [NL-1:0] last_en;
        logic [NL-1:0] seq [$];

        rst = 1; start = 0; abort = 0; layer_finish = '0;
        rb_ena_req = '0; rb_wea_req = '0; bw_ena_req = '0;
        rb_addra_req = '0; rb_dina_req = '0; bw_addra_req = '0;
        for (int i = 0; i < NL; i++) fin_lat[i] = 10;
        @(negedge clk);
        tick(); tick();
        rst = 0;
        chk("reset_cur_layer", cur_layer, 7);
        chk("reset_layer_en", layer_en, 0);
        chk("reset_busy_done_err", {busy, done, err}, 0);

        // Stray finish while idle does nothing.
        stray = 6'b000010; tick();
        chk("idle_stray_busy", busy, 0);

        // Full pass, each layer finishing after 10 enabled cycles.
        start = 1; tick();
        n = 1; busy_n = 0; done_n = 0; done_at = 0; last_en = '0;
        while (n < 80) begin
            if (n == 3) stray = 6'b000010;   // stray finish[1] during layer 0
            if (busy) busy_n++;
            if (done) begin done_n++; done_at = n; end
            if (layer_en != 0 && layer_en != last_en) seq.push_back(layer_en);
            last_en = layer_en;
            tick(); n++;
        end
        chk("pass_busy_cycles", busy_n, 70);
        chk("pass_done_count", done_n, 1);
        chk("pass_done_cycle", done_at, 71);
        nseq = seq.size();
        chk("pass_en_steps", nseq, 6);
        ok = 1;
        for (int i = 0; i < nseq && i < NL; i++) if (seq[i] != (NL'(1) << i)) ok = 0;
        chk("pass_en_walk", ok, 1);

        // BRAM mux follows layer 4 and blanks during the following gap.
        start = 1; tick();
        n = 0;
        while (m_layer != 4 && n < 200) begin tick(); n++; end
        chk("wait_layer4", m_layer, 4);
        rand_req = 0;
        for (int i = 0; i < NL; i++) rb_addra_req[15*i +: 15] = 15'h7FFF;
        rb_addra_req[60 +: 15] = 15'd18400;
        rb_ena_req = 6'b010000;
        #1;
        chk("mux_l4_addra", result_bram_addra, 18400);
        chk("mux_l4_ena", result_bram_ena, 1);
        n = 0;
        while (m_layer >= 0 && n < 50) begin tick(); n++; end
        #1;
        chk("mux_gap_ena", result_bram_ena, 0);
        chk("mux_gap_addra", result_bram_addra, 0);
        rand_req = 1;
        run_to_idle(200);

        // Layer 2 never finishes: timeout after 64 enabled cycles, sticky.
        fin_lat[2] = 0;
        start = 1; tick();
        n = 0; busy_n = 0;
        while (!m_err && n < 300) begin
            if (layer_en == 6'b000100) busy_n++;
            tick(); n++;
        end
        chk("tmo_layer2_cycles", busy_n, 64);
        chk("tmo_err", err, 1);
        chk("tmo_en_busy", {layer_en, busy}, 0);
        start = 1; tick(); tick();
        chk("tmo_start_ignored", {busy, err}, 2'b01);
        rst = 1; tick(); rst = 0;
        chk("tmo_rst_clears", err, 0);
        fin_lat[2] = 10;

        // Abort in the same cycle as finish[3].
        start = 1; tick();
        n = 0;
        while (!(m_layer == 3 && m_age == 4) && n < 200) begin tick(); n++; end
        abort = 1; stray = 6'b001000; tick(); abort = 0;
        chk("abort_state", {layer_en, cur_layer, busy, done}, {6'b0, 3'd7, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++) tick();
        chk("abort_no_done", done, 0);

        // Reset right after start.
        start = 1; tick();
        rst = 1; tick(); rst = 0;
        chk("rst_after_start", {layer_en, cur_layer, busy, done, err}, {6'b0, 3'd7, 3'b0});

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if (m_idle() && $urandom_range(0, 5) == 0) begin
                for (int i = 0; i < NL; i++) begin
                    case ($urandom_range(0, 19))
                        0:       fin_lat[i] = 0;
                        1:       fin_lat[i] = 70;
                        default: fin_lat[i] = $urandom_range(1, 12);
                    endcase
                end
                start = 1;
            end else if ($urandom_range(0, 19) == 0) start = 1;
            if ($urandom_range(0, 3) == 0) stray = NL'($urandom);
            abort = ($urandom_range(0, 199) == 0);
            rst = (m_err && $urandom_range(0, 9) == 0) || ($urandom_range(0, 499) == 0);
            tick();
            abort = 0; rst = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
